// File: rtl/transfer_controller_if.sv
// Bundle of scanner/host handshake signals around the transfer controller.
//   master : controller side (drives start/flush/status, samples ready/progress/host)
//   slave  : scanner + host side (drives ready/progress/host, samples controller outputs)
interface transfer_controller_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ready0;
  logic             ready1;
  logic [3:0]       progress0;
  logic [3:0]       progress1;
  logic             host_busy;
  logic             host_flush;
  logic             start_transfer0;
  logic             start_transfer1;
  logic             flush0;
  logic             flush1;
  logic [1:0]       active;
  logic [1:0]       state;
  logic [CNT_W-1:0] xfer_count;
  logic             timeout_err;

  modport master (
    input  ready0, ready1, progress0, progress1, host_busy, host_flush,
    output start_transfer0, start_transfer1, flush0, flush1, active, state,
           xfer_count, timeout_err
  );

  modport slave (
    output ready0, ready1, progress0, progress1, host_busy, host_flush,
    input  start_transfer0, start_transfer1, flush0, flush1, active, state,
           xfer_count, timeout_err
  );
endinterface

// File: rtl/transfer_controller.sv
// Arbitrates transfers from two scanners to the host, one at a time, round-robin.
// Issues a one-cycle start pulse, watches the owner's buffer drain, aborts stalled
// transfers with a watchdog, and flushes scanner buffers on host request or abort.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : handshake/status bundle (master side), see transfer_controller_if
module transfer_controller #(
  parameter int unsigned FLUSH_CYCLES = 5,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned TMR_W        = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  transfer_controller_if.master  bus
);
  localparam int unsigned FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic             owner_q,  owner_d;
  logic             last_q,   last_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic [FL_W-1:0]  fcnt_q,   fcnt_d;
  logic [1:0]       ftgt_q,   ftgt_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             err_q,    err_d;
  logic [1:0]       start_q,  start_d;
  logic [1:0]       flush_q,  flush_d;
  logic [1:0]       active_q, active_d;

  logic [3:0] owner_progress;
  logic [1:0] owner_onehot;

  assign owner_progress = owner_q ? bus.progress1 : bus.progress0;
  assign owner_onehot   = owner_q ? 2'b10 : 2'b01;

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    fcnt_d  = fcnt_q;
    ftgt_d  = ftgt_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.host_flush) begin
          state_d = FLUSH;
          ftgt_d  = 2'b11;
          fcnt_d  = FL_W'(FLUSH_CYCLES - 1);
        end else if (!bus.host_busy && (bus.ready0 || bus.ready1)) begin
          state_d = GRANT;
          // Tie goes to the scanner not served last.
          owner_d = (bus.ready0 && bus.ready1) ? !last_q : bus.ready1;
        end
      end
      GRANT: begin
        if (bus.host_flush) begin
          state_d = FLUSH;
          ftgt_d  = 2'b11;
          fcnt_d  = FL_W'(FLUSH_CYCLES - 1);
        end else begin
          state_d = XFER;
          timer_d = '0;
        end
      end
      XFER: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.host_flush) begin
          state_d = FLUSH;
          ftgt_d  = 2'b11;
          fcnt_d  = FL_W'(FLUSH_CYCLES - 1);
        end else if (owner_progress == 4'd0) begin
          state_d = IDLE;
          last_d  = owner_q;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = FLUSH;
          err_d   = 1'b1;
          ftgt_d  = owner_onehot;
          fcnt_d  = FL_W'(FLUSH_CYCLES - 1);
        end
      end
      default: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - FL_W'(1);
      end
    endcase

    start_d  = 2'b00;
    flush_d  = 2'b00;
    active_d = 2'b00;
    if (state_d == GRANT) start_d = owner_d ? 2'b10 : 2'b01;
    if (state_d == GRANT || state_d == XFER) active_d = owner_d ? 2'b10 : 2'b01;
    if (state_d == FLUSH) flush_d = ftgt_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      timer_q  <= '0;
      fcnt_q   <= '0;
      ftgt_q   <= 2'b00;
      count_q  <= '0;
      err_q    <= 1'b0;
      start_q  <= 2'b00;
      flush_q  <= 2'b00;
      active_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      fcnt_q   <= fcnt_d;
      ftgt_q   <= ftgt_d;
      count_q  <= count_d;
      err_q    <= err_d;
      start_q  <= start_d;
      flush_q  <= flush_d;
      active_q <= active_d;
    end
  end

  assign bus.state           = state_q;
  assign bus.active          = active_q;
  assign bus.start_transfer0 = start_q[0];
  assign bus.start_transfer1 = start_q[1];
  assign bus.flush0          = flush_q[0];
  assign bus.flush1          = flush_q[1];
  assign bus.xfer_count      = count_q;
  assign bus.timeout_err     = err_q;
endmodule
